// File: rtl/dog_img.sv
// Difference-of-Gaussians stage: streams two blurred images and writes the signed difference b - a.
// Optional feature macro DOG_SAT_EN: saturates the output to BIT_DEPTH signed bits.
module dog_img #(
    parameter int BIT_DEPTH = 8,
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
`ifdef DOG_SAT_EN
    localparam int OUT_W    = BIT_DEPTH
`else
    localparam int OUT_W    = BIT_DEPTH + 1
`endif
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]     ext_read_addr,
    output logic                                ext_read_addr_valid,
    input  logic [BIT_DEPTH-1:0]                ext_pixel_a_in,
    input  logic [BIT_DEPTH-1:0]                ext_pixel_b_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]     ext_write_addr,
    output logic                                ext_write_valid,
    output logic [OUT_W-1:0]                    ext_pixel_out,
    input  logic                                start_in,
    output logic                                dog_done
);

    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH*HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

    state_t              state, state_next;
    logic [AW-1:0]       cnt, cnt_next;
    logic                done_next;
    logic                v1, v2;
    logic [AW-1:0]       a1, a2;
    logic [BIT_DEPTH:0]  diff;
    logic [OUT_W-1:0]    pix_next;

    assign ext_read_addr       = cnt;
    assign ext_read_addr_valid = (state == StRead);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        unique case (state)
            StIdle: begin
                if (start_in) begin
                    state_next = StRead;
                    cnt_next   = '0;
                end
            end
            StRead: begin
                if (cnt == LAST_ADDR) state_next = StDrain;
                else                  cnt_next   = cnt + 1'b1;
            end
            StDrain: begin
                // v2 low means the output register empties on this edge too
                if (!v1 && !v2) begin
                    state_next = StIdle;
                    done_next  = 1'b1;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        diff = {1'b0, ext_pixel_b_in} - {1'b0, ext_pixel_a_in};
`ifdef DOG_SAT_EN
        if (!diff[BIT_DEPTH] && diff[BIT_DEPTH-1]) begin
            pix_next = {1'b0, {(BIT_DEPTH-1){1'b1}}};
        end else if (diff[BIT_DEPTH] && !diff[BIT_DEPTH-1]) begin
            pix_next = {1'b1, {(BIT_DEPTH-1){1'b0}}};
        end else begin
            pix_next = diff[BIT_DEPTH-1:0];
        end
`else
        pix_next = diff;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= StIdle;
            cnt             <= '0;
            dog_done        <= 1'b0;
            v1              <= 1'b0;
            v2              <= 1'b0;
            a1              <= '0;
            a2              <= '0;
            ext_write_valid <= 1'b0;
            ext_write_addr  <= '0;
            ext_pixel_out   <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            dog_done        <= done_next;
            v1              <= ext_read_addr_valid;
            a1              <= cnt;
            v2              <= v1;
            a2              <= a1;
            ext_write_valid <= v2;
            ext_write_addr  <= a2;
            ext_pixel_out   <= pix_next;
        end
    end

endmodule

// File: tb/tb_dog_img.sv
// Randomized self-checking bench for dog_img on a 4x4 image with a two-cycle-latency BRAM model.
module tb_dog_img;

    localparam int BD = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
`ifdef DOG_SAT_EN
    localparam int OUT_W = BD;
`else
    localparam int OUT_W = BD + 1;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              start_in = 1'b0;
    logic [AW-1:0]     ext_read_addr;
    logic              ext_read_addr_valid;
    logic [BD-1:0]     ext_pixel_a_in, ext_pixel_b_in;
    logic [AW-1:0]     ext_write_addr;
    logic              ext_write_valid;
    logic [OUT_W-1:0]  ext_pixel_out;
    logic              dog_done;

    int checks = 0;
    int errors = 0;
    int mem_a [N];
    int mem_b [N];
    logic [BD-1:0] p1a, p1b;

    dog_img #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .ext_read_addr       (ext_read_addr),
        .ext_read_addr_valid (ext_read_addr_valid),
        .ext_pixel_a_in      (ext_pixel_a_in),
        .ext_pixel_b_in      (ext_pixel_b_in),
        .ext_write_addr      (ext_write_addr),
        .ext_write_valid     (ext_write_valid),
        .ext_pixel_out       (ext_pixel_out),
        .start_in            (start_in),
        .dog_done            (dog_done)
    );

    always #5 clk_in = ~clk_in;

    // Two-stage read latency BRAM pair
    always @(posedge clk_in) begin
        p1a            <= BD'(mem_a[ext_read_addr]);
        p1b            <= BD'(mem_b[ext_read_addr]);
        ext_pixel_a_in <= p1a;
        ext_pixel_b_in <= p1b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_dog(input int a, input int b);
        int d;
        d = b - a;
`ifdef DOG_SAT_EN
        if (d > (2 ** (BD - 1)) - 1) d = (2 ** (BD - 1)) - 1;
        if (d < -(2 ** (BD - 1)))    d = -(2 ** (BD - 1));
`endif
        return OUT_W'(d);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = int'($urandom % (1 << BD));
            mem_b[i] = int'($urandom % (1 << BD));
        end
    endtask

    // Checks every cycle of one pass against the timing rules; k counts cycles after the start edge.
    task automatic run_pass(input bit mid_pulse, input bit chain, input bit started);
        if (!started) begin
            @(negedge clk_in);
            start_in = 1'b1;
        end
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (mid_pulse && (k == 5 || k == N + 2)) start_in = 1'b1;
            if (chain && k == N + 4) start_in = 1'b1;
            check("rd_valid", 32'(ext_read_addr_valid), 32'(k <= N));
            if (k <= N) check("rd_addr", 32'(ext_read_addr), 32'(k - 1));
            check("wr_valid", 32'(ext_write_valid), 32'(k >= 4 && k <= N + 3));
            if (k >= 4 && k <= N + 3) begin
                check("wr_addr", 32'(ext_write_addr), 32'(k - 4));
                check("pixel", 32'(ext_pixel_out), 32'(ref_dog(mem_a[k-4], mem_b[k-4])));
            end
            check("done", 32'(dog_done), 32'(k == N + 4));
        end
        if (!chain) begin
            @(negedge clk_in);
            check("idle_rd_valid", 32'(ext_read_addr_valid), 32'd0);
            check("idle_wr_valid", 32'(ext_write_valid), 32'd0);
            check("idle_done", 32'(dog_done), 32'd0);
            check("idle_rd_addr_hold", 32'(ext_read_addr), 32'(N - 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(ext_read_addr), 32'd0);
        check({tag, "_rd_valid"}, 32'(ext_read_addr_valid), 32'd0);
        check({tag, "_wr_addr"}, 32'(ext_write_addr), 32'd0);
        check({tag, "_wr_valid"}, 32'(ext_write_valid), 32'd0);
        check({tag, "_pixel"}, 32'(ext_pixel_out), 32'd0);
        check({tag, "_done"}, 32'(dog_done), 32'd0);
    endtask

    initial begin
        fill_random();
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b1;
        repeat (5) @(negedge clk_in);

        // Ramp minus constant: writes 20 down to 5
        for (int i = 0; i < N; i++) begin
            mem_a[i] = i;
            mem_b[i] = 20;
        end
        run_pass(1'b0, 1'b0, 1'b0);

        // Sign and saturation extremes
        fill_random();
        mem_a[0] = 200; mem_b[0] = 10;
        mem_a[1] = 255; mem_b[1] = 0;
        mem_a[2] = 0;   mem_b[2] = 255;
        mem_a[3] = 10;  mem_b[3] = 200;
        mem_a[4] = 0;   mem_b[4] = 0;
        run_pass(1'b0, 1'b0, 1'b0);
`ifdef DOG_SAT_EN
        check("sat_neg_model", 32'(ref_dog(mem_a[0], mem_b[0])), 32'h80);
`else
        check("neg190_model", 32'(ref_dog(mem_a[0], mem_b[0])), 32'h142);
`endif

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_pass(1'b0, 1'b0, 1'b0);
        end

        // Extra start pulses in READ and DRAIN must be ignored
        fill_random();
        run_pass(1'b1, 1'b0, 1'b0);

        // Reset while address 7 is being read
        fill_random();
        @(negedge clk_in);
        start_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
        end
        check("pre_rst_rd_addr", 32'(ext_read_addr), 32'd7);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        check_all_zero("midrst");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            check("post_rst_wr_valid", 32'(ext_write_valid), 32'd0);
            check("post_rst_rd_valid", 32'(ext_read_addr_valid), 32'd0);
            check("post_rst_done", 32'(dog_done), 32'd0);
        end
        run_pass(1'b0, 1'b0, 1'b0);

        // Back-to-back: restart in the done cycle
        fill_random();
        run_pass(1'b0, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
